// File: rtl/pool2x2_stream.sv
// Streaming 2x2 / stride-2 max/average pooling over a raster pixel stream with all channel lanes packed per beat.
// Result registered one cycle after the beat at odd row / odd col; no backpressure, every valid_in beat is accepted.
module pool2x2_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 32,
  parameter int WIDTH      = 14,
  parameter int HEIGHT     = 14
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           mode,
  input  logic                           valid_in,
  input  logic [DATA_WIDTH*CHANNELS-1:0] i_data,
  output logic [DATA_WIDTH*CHANNELS-1:0] o_data,
  output logic                           valid_out,
  output logic                           frame_done
);

  localparam int DW  = DATA_WIDTH;
  localparam int HW  = DATA_WIDTH + 1;
  localparam int CW  = $clog2(WIDTH);
  localparam int RW  = $clog2(HEIGHT);
  localparam int LBN = WIDTH / 2;
  localparam int LW  = (LBN > 1) ? $clog2(LBN) : 1;

  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic                   mode_q, mode_d;
  logic [DW*CHANNELS-1:0] o_data_q, o_data_d;
  logic                   valid_out_q, valid_out_d;
  logic                   frame_done_q, frame_done_d;

  logic [DW*CHANNELS-1:0] pair_q;
  logic [HW*CHANNELS-1:0] lb_q [LBN];

  logic                   accept;
  logic                   col_last, row_last;
  logic [LW-1:0]          lb_idx;
  logic [HW*CHANNELS-1:0] h_dat;
  logic [DW*CHANNELS-1:0] v_dat;

  logic signed [DW-1:0]   lane_a, lane_b;
  logic signed [HW-1:0]   lane_h, lane_l;
  logic signed [HW:0]     lane_s;
  logic        [DW-1:0]   lane_o;

  // A beat presented alongside flush belongs to neither frame, so it is dropped.
  assign accept   = valid_in & ~flush;
  assign col_last = (col_q == CW'(WIDTH - 1));
  assign row_last = (row_q == RW'(HEIGHT - 1));
  assign lb_idx   = LW'(col_q >> 1);

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    mode_d       = mode_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    if (flush) begin
      col_d = '0;
      row_d = '0;
    end else if (valid_in) begin
      if (col_q == '0 && row_q == '0) begin
        mode_d = mode;
      end
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      valid_out_d  = col_q[0] & row_q[0];
      frame_done_d = col_last & row_last;
    end
  end

  // Horizontal pair uses DW+1 bits so the average path keeps its carry into the vertical sum.
  always_comb begin
    h_dat  = '0;
    v_dat  = '0;
    lane_a = '0;
    lane_b = '0;
    lane_h = '0;
    lane_l = '0;
    lane_s = '0;
    lane_o = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      lane_a = pair_q[k*DW +: DW];
      lane_b = i_data[k*DW +: DW];
      if (mode_q) begin
        lane_h = {lane_a[DW-1], lane_a} + {lane_b[DW-1], lane_b};
      end else begin
        lane_h = (lane_a > lane_b) ? {lane_a[DW-1], lane_a} : {lane_b[DW-1], lane_b};
      end
      h_dat[k*HW +: HW] = lane_h;
      lane_l = lb_q[lb_idx][k*HW +: HW];
      lane_s = {lane_l[HW-1], lane_l} + {lane_h[HW-1], lane_h};
      if (mode_q) begin
        lane_o = DW'(lane_s >>> 2);
      end else begin
        lane_o = DW'((lane_l > lane_h) ? lane_l : lane_h);
      end
      v_dat[k*DW +: DW] = lane_o;
    end
  end

  always_comb begin
    o_data_d = valid_out_d ? v_dat : o_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      mode_q       <= 1'b0;
      o_data_q     <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      mode_q       <= mode_d;
      o_data_q     <= o_data_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Datapath storage needs no reset: it is always written before it is read within a frame.
  always_ff @(posedge clk) begin
    if (accept && !col_q[0]) begin
      pair_q <= i_data;
    end
    if (accept && col_q[0] && !row_q[0]) begin
      lb_q[lb_idx] <= h_dat;
    end
  end

  assign o_data     = o_data_q;
  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pool2x2_stream.sv
// Directed bench: a 4x4x2 8-bit instance for value/mode/flush/reset cases and a default 14x14x32 instance for timing and count.
module tb_pool2x2_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s_flush = 1'b0, s_mode = 1'b0, s_vin = 1'b0;
  logic [15:0] s_din = '0;
  logic [15:0] s_dout;
  logic        s_vo, s_fd;

  logic          b_flush = 1'b0, b_mode = 1'b0, b_vin = 1'b0;
  logic [1023:0] b_din = '0;
  logic [1023:0] b_dout;
  logic          b_vo, b_fd;

  pool2x2_stream #(.DATA_WIDTH(8), .CHANNELS(2), .WIDTH(4), .HEIGHT(4)) u_small (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .mode(s_mode), .valid_in(s_vin),
    .i_data(s_din), .o_data(s_dout), .valid_out(s_vo), .frame_done(s_fd)
  );

  pool2x2_stream u_big (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .mode(b_mode), .valid_in(b_vin),
    .i_data(b_din), .o_data(b_dout), .valid_out(b_vo), .frame_done(b_fd)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Captured small-instance outputs: {frame_done, lane1, lane0}.
  logic [16:0] outq[$];
  always @(negedge clk) begin
    if (s_vo) outq.push_back({s_fd, s_dout});
  end

  byte exp_max0[4] = '{5, 7, 13, 15};
  byte exp_max1[4] = '{0, -2, -8, -10};
  byte exp_avg0[4] = '{2, 4, 10, 12};
  byte exp_avg1[4] = '{-3, -5, -11, -13};

  task automatic send_small(input logic m, input int n_beats, input bit gap, input int flip_at);
    logic [7:0] p;
    s_mode = m;
    for (int i = 0; i < n_beats; i++) begin
      p = 8'(4 * (i / 4) + (i % 4));
      if (i == flip_at) s_mode = ~m;
      s_vin = 1'b1;
      s_din = {8'(-p), p};
      @(posedge clk); #1;
      s_vin = 1'b0;
      if (gap) begin
        @(posedge clk); #1;
      end
    end
    s_vin = 1'b0;
  endtask

  task automatic drain();
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_frame(input string tag, input bit avg);
    logic [16:0] e;
    logic [7:0]  x0, x1;
    for (int i = 0; i < 4; i++) begin
      e  = (outq.size() > 0) ? outq.pop_front() : 17'h0;
      x0 = avg ? exp_avg0[i] : exp_max0[i];
      x1 = avg ? exp_avg1[i] : exp_max1[i];
      chk($sformatf("%s_l0_%0d", tag, i), e[7:0], x0);
      chk($sformatf("%s_l1_%0d", tag, i), e[15:8], x1);
      chk($sformatf("%s_fd_%0d", tag, i), e[16], (i == 3));
    end
  endtask

  int   big_n = 0;
  logic pend_vo = 1'b0, pend_fd = 1'b0;

  task automatic check_big();
    int p;
    chk("big_vo", b_vo, pend_vo);
    chk("big_fd", b_fd, pend_fd);
    if (b_vo) begin
      p = (2 * (big_n / 7) + 1) * 14 + 2 * (big_n % 7) + 1;
      chk($sformatf("big_l0_%0d", big_n), b_dout[31:0], 32'(p * 64));
      chk($sformatf("big_l31_%0d", big_n), b_dout[1023:992], 32'(p * 64 + 31));
      big_n++;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_s_vo", s_vo, 0);
    chk("rst_s_fd", s_fd, 0);
    chk("rst_s_dout", s_dout, 0);
    chk("rst_b_vo", b_vo, 0);
    chk("rst_b_dout", b_dout[63:0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_small(1'b0, 16, 1'b0, -1);
    drain();
    chk("max_cnt", outq.size(), 4);
    check_frame("max", 1'b0);

    send_small(1'b1, 16, 1'b0, -1);
    drain();
    chk("avg_cnt", outq.size(), 4);
    check_frame("avg", 1'b1);

    send_small(1'b0, 16, 1'b1, -1);
    drain();
    chk("gap_cnt", outq.size(), 4);
    check_frame("gap", 1'b0);

    send_small(1'b0, 16, 1'b0, 6);
    send_small(1'b1, 16, 1'b0, -1);
    drain();
    chk("sw_cnt", outq.size(), 8);
    check_frame("sw_f1", 1'b0);
    check_frame("sw_f2", 1'b1);

    // Flush after 6 beats: the already-computed first window still emerges, the flush-cycle beat is dropped.
    outq.delete();
    send_small(1'b0, 6, 1'b0, -1);
    s_flush = 1'b1;
    s_vin   = 1'b1;
    s_din   = 16'h7f7f;
    @(posedge clk); #1;
    s_flush = 1'b0;
    s_vin   = 1'b0;
    drain();
    chk("fl_cnt", outq.size(), 1);
    chk("fl_l0", (outq.size() > 0) ? outq[0][7:0] : 8'h0, 8'd5);
    outq.delete();
    send_small(1'b0, 16, 1'b0, -1);
    drain();
    chk("fl_new_cnt", outq.size(), 4);
    check_frame("fl_new", 1'b0);

    // Reset pulse right after the 6th beat clears the pending output before it can be sampled.
    send_small(1'b1, 6, 1'b0, -1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drain();
    chk("rs_cnt", outq.size(), 0);
    send_small(1'b0, 16, 1'b0, -1);
    drain();
    chk("rs_new_cnt", outq.size(), 4);
    check_frame("rs_new", 1'b0);

    b_mode = 1'b0;
    for (int i = 0; i < 196; i++) begin
      b_vin = 1'b1;
      for (int k = 0; k < 32; k++) b_din[k*32 +: 32] = 32'(i * 64 + k);
      @(negedge clk);
      check_big();
      pend_vo = ((i / 14) % 2 == 1) && ((i % 14) % 2 == 1);
      pend_fd = (i == 195);
      @(posedge clk); #1;
    end
    b_vin = 1'b0;
    @(negedge clk);
    check_big();
    pend_vo = 1'b0;
    pend_fd = 1'b0;
    @(negedge clk);
    check_big();
    chk("big_cnt", big_n, 49);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
